obi_req_buffer: RTL and testbench

- Parametrised OBI request buffer between a core request port and the bus. Successor to the single-entry request register.
- Holds up to DEPTH accepted requests in order and replays them downstream under the bus grant.
- Flat, width-parametrised fields replace the fixed request struct.
- Adds a synchronous flush, occupancy/full/empty status and a programmable almost-full threshold.

---
 rtl/obi_req_buffer.sv | 121 ++++++++++++
 tb/tb_obi_req_buffer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/obi_req_buffer.sv
// OBI request buffer: an in-order circular queue of DEPTH accepted core
// requests, replayed on the bus under gnt_i, with flush and occupancy status.
module obi_req_buffer #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned AFULL_TH   = DEPTH - 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          req_i,
    input  logic [ADDR_WIDTH-1:0]         addr_i,
    input  logic                          we_i,
    input  logic [DATA_WIDTH/8-1:0]       be_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    output logic                          gnt_o,
    output logic                          req_o,
    output logic [ADDR_WIDTH-1:0]         addr_o,
    output logic                          we_o,
    output logic [DATA_WIDTH/8-1:0]       be_o,
    output logic [DATA_WIDTH-1:0]         wdata_o,
    input  logic                          gnt_i,
    output logic [$clog2(DEPTH+1)-1:0]    count_o,
    output logic                          empty_o,
    output logic                          afull_o
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C    = CNT_W'(AFULL_TH);
    localparam logic [PTR_W-1:0] PTR_LAST_C = PTR_W'(DEPTH - 1);

    if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
        $error("obi_req_buffer: DEPTH must be in 1..16");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
        $error("obi_req_buffer: AFULL_TH must be in 1..DEPTH");
    end

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [BE_WIDTH-1:0]   be;
        logic [DATA_WIDTH-1:0] wdata;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               empty;
    logic               push;
    logic               pop;
    entry_t             head;

    // Wrap explicitly so non-power-of-two depths never index past the array.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST_C) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty = (count_q == '0);
    assign pop   = req_o & gnt_i;
    // A full buffer can still accept when the head leaves in the same cycle.
    assign gnt_o = req_i & ~flush_i & ((count_q < DEPTH_C) | pop);
    assign push  = gnt_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = next_ptr(wptr_q);
            if (pop)  rptr_d = next_ptr(rptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the output mux masks it while empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= '{addr: addr_i, we: we_i, be: be_i, wdata: wdata_i};
        end
    end

    assign head    = mem_q[rptr_q];
    assign req_o   = ~empty;
    assign addr_o  = empty ? '0 : head.addr;
    assign we_o    = empty ? 1'b0 : head.we;
    assign be_o    = empty ? '0 : head.be;
    assign wdata_o = empty ? '0 : head.wdata;

    assign count_o = count_q;
    assign empty_o = empty;
    assign afull_o = (count_q >= AFULL_C);

endmodule

// File: tb/tb_obi_req_buffer.sv
// Self-checking bench for obi_req_buffer: three depths share one stimulus
// bus; each phase checks the instance it targets against constants or a queue model.
module tb_obi_req_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        req_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        gnt_i;

    logic        d1_gnt_o, d1_req_o, d1_we_o, d1_empty_o, d1_afull_o;
    logic [31:0] d1_addr_o, d1_wdata_o;
    logic [3:0]  d1_be_o;
    logic [0:0]  d1_count_o;

    logic        d2_gnt_o, d2_req_o, d2_we_o, d2_empty_o, d2_afull_o;
    logic [31:0] d2_addr_o, d2_wdata_o;
    logic [3:0]  d2_be_o;
    logic [1:0]  d2_count_o;

    logic        d3_gnt_o, d3_req_o, d3_we_o, d3_empty_o, d3_afull_o;
    logic [31:0] d3_addr_o, d3_wdata_o;
    logic [3:0]  d3_be_o;
    logic [1:0]  d3_count_o;

    always #5 clk_i = ~clk_i;

    obi_req_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(1), .AFULL_TH(1)) u_d1 (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .req_i(req_i), .addr_i(addr_i),
        .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .gnt_o(d1_gnt_o), .req_o(d1_req_o),
        .addr_o(d1_addr_o), .we_o(d1_we_o), .be_o(d1_be_o), .wdata_o(d1_wdata_o),
        .gnt_i(gnt_i), .count_o(d1_count_o), .empty_o(d1_empty_o), .afull_o(d1_afull_o));

    obi_req_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(2)) u_d2 (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .req_i(req_i), .addr_i(addr_i),
        .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .gnt_o(d2_gnt_o), .req_o(d2_req_o),
        .addr_o(d2_addr_o), .we_o(d2_we_o), .be_o(d2_be_o), .wdata_o(d2_wdata_o),
        .gnt_i(gnt_i), .count_o(d2_count_o), .empty_o(d2_empty_o), .afull_o(d2_afull_o));

    obi_req_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(3)) u_d3 (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .req_i(req_i), .addr_i(addr_i),
        .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .gnt_o(d3_gnt_o), .req_o(d3_req_o),
        .addr_o(d3_addr_o), .we_o(d3_we_o), .be_o(d3_be_o), .wdata_o(d3_wdata_o),
        .gnt_i(gnt_i), .count_o(d3_count_o), .empty_o(d3_empty_o), .afull_o(d3_afull_o));

    typedef struct {
        logic        req;
        logic        flush;
        logic        gnt;
        logic [31:0] addr;
        logic        exp_gnt;
        logic        exp_req;
        logic [31:0] exp_addr;
        int          exp_cnt;
        logic        exp_afull;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } item_t;

    vec_t  vecs [13];
    item_t sb [$];
    item_t exp_item;
    item_t act_item;
    int    n_cmp  = 0;
    int    n_fail = 0;

    task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        flush_i = 1'b0;
        req_i   = 1'b0;
        addr_i  = '0;
        we_i    = 1'b0;
        be_i    = '0;
        wdata_i = '0;
        gnt_i   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        // DEPTH=2 (AFULL_TH=1): fill, backpressure, full pass-through, drain, flush.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h100, 1'b1, 1'b0, 32'h000, 0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h104, 1'b1, 1'b1, 32'h100, 1, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h108, 1'b0, 1'b1, 32'h100, 2, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h108, 1'b1, 1'b1, 32'h100, 2, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b1, 32'h104, 2, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h000, 1'b0, 1'b1, 32'h104, 2, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'h000, 1'b0, 1'b1, 32'h108, 1, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h200, 1'b1, 1'b0, 32'h000, 0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h204, 1'b1, 1'b1, 32'h200, 1, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 32'h208, 1'b0, 1'b1, 32'h200, 2, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h20C, 1'b1, 1'b0, 32'h000, 0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h000, 1'b0, 1'b1, 32'h20C, 1, 1'b1};

        do_reset();
        check("reset_req", d2_req_o, 1'b0);
        check("reset_empty", d2_empty_o, 1'b1);
        check("reset_afull", d2_afull_o, 1'b0);

        for (int i = 0; i < 13; i++) begin
            idle_inputs();
            req_i   = vecs[i].req;
            flush_i = vecs[i].flush;
            gnt_i   = vecs[i].gnt;
            addr_i  = vecs[i].addr;
            #3;
            check($sformatf("v%0d_gnt_o", i), d2_gnt_o, vecs[i].exp_gnt);
            check($sformatf("v%0d_req_o", i), d2_req_o, vecs[i].exp_req);
            check($sformatf("v%0d_addr_o", i), d2_addr_o, vecs[i].exp_addr);
            check($sformatf("v%0d_count_o", i), d2_count_o, 73'(vecs[i].exp_cnt));
            check($sformatf("v%0d_afull_o", i), d2_afull_o, vecs[i].exp_afull);
            check($sformatf("v%0d_empty_o", i), d2_empty_o, 73'(vecs[i].exp_cnt == 0));
            next_cycle();
        end

        // Asynchronous reset with two entries held (0x20C from the table, plus 0x300).
        idle_inputs();
        req_i  = 1'b1;
        addr_i = 32'h300;
        next_cycle();
        idle_inputs();
        #1;
        check("pre_rst_count", d2_count_o, 2);
        check("pre_rst_addr", d2_addr_o, 32'h20C);
        #1;
        rst_i = 1'b1;
        #1;
        check("async_rst_req", d2_req_o, 1'b0);
        check("async_rst_count", d2_count_o, 0);
        check("async_rst_empty", d2_empty_o, 1'b1);
        check("async_rst_addr", d2_addr_o, 32'h0);
        check("async_rst_gnt", d2_gnt_o, 1'b0);
        next_cycle();
        rst_i = 1'b0;
        next_cycle();
        check("post_rst_req", d2_req_o, 1'b0);

        // DEPTH=1 streaming at one request per cycle with gnt_i held high.
        sb.delete();
        for (int k = 0; k <= 8; k++) begin
            idle_inputs();
            gnt_i   = 1'b1;
            req_i   = (k < 8);
            addr_i  = 32'(k * 4);
            we_i    = 1'b1;
            be_i    = 4'hF;
            wdata_i = 32'(k);
            #3;
            check($sformatf("stream%0d_gnt_o", k), d1_gnt_o, 73'(k < 8));
            if (k >= 1) check($sformatf("stream%0d_latency", k), d1_req_o, 1'b1);
            if (d1_req_o && gnt_i) begin
                if (sb.size() == 0) begin
                    check("stream_unexpected_req", d1_req_o, 1'b0);
                end else begin
                    exp_item = sb.pop_front();
                    act_item = '{addr: d1_addr_o, we: d1_we_o, be: d1_be_o, wdata: d1_wdata_o};
                    check($sformatf("stream%0d_item", k), act_item, exp_item);
                end
            end
            if (d1_gnt_o) sb.push_back('{addr: addr_i, we: we_i, be: be_i, wdata: wdata_i});
            next_cycle();
        end
        #3;
        check("stream_drained_req", d1_req_o, 1'b0);
        check("stream_sb_empty", sb.size(), 0);

        // DEPTH=3 random traffic with occasional flushes against a queue model.
        do_reset();
        sb.delete();
        for (int c = 0; c < 1000; c++) begin
            logic exp_gnt;
            logic do_pop;
            idle_inputs();
            req_i   = 1'($urandom_range(0, 1));
            gnt_i   = ($urandom_range(0, 9) < 6);
            flush_i = ($urandom_range(0, 49) == 0);
            addr_i  = $urandom;
            we_i    = 1'($urandom_range(0, 1));
            be_i    = 4'($urandom_range(0, 15));
            wdata_i = $urandom;
            #3;
            do_pop  = (sb.size() > 0) && gnt_i;
            exp_gnt = req_i && !flush_i && ((sb.size() < 3) || do_pop);
            check("rnd_gnt_o", d3_gnt_o, exp_gnt);
            check("rnd_count_o", d3_count_o, 73'(sb.size()));
            check("rnd_req_o", d3_req_o, 73'(sb.size() > 0));
            act_item = '{addr: d3_addr_o, we: d3_we_o, be: d3_be_o, wdata: d3_wdata_o};
            if (sb.size() > 0) check("rnd_head", act_item, sb[0]);
            else               check("rnd_idle_fields", act_item, '0);
            if (do_pop) void'(sb.pop_front());
            if (flush_i) sb.delete();
            else if (exp_gnt) sb.push_back('{addr: addr_i, we: we_i, be: be_i, wdata: wdata_i});
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
